// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - CSR addresses touched by the sequencer (mstatus, mtvec, mepc, mcause)
//   - mstatus bit positions (MIE, MPIE, MPP)
//   - exception / interrupt cause codes
//   - sequencer state encoding
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_MTI     = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T_SAVE,
        ST_T_STATUS,
        ST_M_RESTORE,
        ST_REDIR
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap sequencer sitting between commit and the CSR file.
// At an instruction boundary it takes a timer interrupt, ecall or mret, walks
// the CSR file through a fixed sequence of reads/writes while stalling the
// pipeline, and finishes with a one-cycle PC redirect.
//
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   commit_valid/pc       instruction at the commit boundary and its PC
//   commit_ecall/mret     instruction type flags
//   timer_interrupt       pending machine timer interrupt
//   csr_rdata             CSR read data, combinational from csr_raddr
//   csr_ren/raddr         CSR read port
//   csr_wen1/waddr1/wdata1, csr_wen2/waddr2/wdata2   CSR write ports
//   commit_kill           squash the committing instruction (IDLE only)
//   stall                 hold the pipeline while a sequence is running
//   redirect_valid/pc     one-cycle redirect strobe and target
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic            commit_ecall,
    input  logic            commit_mret,
    input  logic            timer_interrupt,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_ren,
    output logic [11:0]     csr_raddr,
    output logic            csr_wen1,
    output logic [11:0]     csr_waddr1,
    output logic [XLEN-1:0] csr_wdata1,
    output logic            csr_wen2,
    output logic [11:0]     csr_waddr2,
    output logic [XLEN-1:0] csr_wdata2,
    output logic            commit_kill,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] IRQ_CAUSE   = (XLEN'(1) << (XLEN - 1)) | XLEN'(CAUSE_MTI);
    localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(CAUSE_ECALL_M);

    trap_state_e     state_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] status_q;
    logic            wen1_q;
    logic [11:0]     waddr1_q;
    logic [XLEN-1:0] wdata1_q;
    logic            wen2_q;
    logic [11:0]     waddr2_q;
    logic [XLEN-1:0] wdata2_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            takeIrq;
    logic            takeEcall;
    logic            takeMret;

    // Trap entry view of mstatus: stash MIE into MPIE, disable interrupts,
    // and record machine mode as the previous privilege.
    function automatic logic [XLEN-1:0] trapStatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mret view of mstatus: restore MIE from MPIE and re-arm MPIE.
    function automatic logic [XLEN-1:0] mretStatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Handler entry point. Only interrupts use vectored mode; any MODE other
    // than 01 falls back to direct. The offset add wraps at XLEN bits.
    function automatic logic [XLEN-1:0] trapTarget(input logic [XLEN-1:0] tvec,
                                                   input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = {tvec[XLEN-1:2], 2'b00};
        if (VECTORED_EN && (tvec[1:0] == 2'b01) && cause[XLEN-1]) begin
            return base + (XLEN'(cause[5:0]) << 2);
        end
        return base;
    endfunction

    // Event decode at the commit boundary. In IDLE the read port always
    // presents mstatus, so csr_rdata is the live status word here.
    always_comb begin
        takeIrq   = 1'b0;
        takeEcall = 1'b0;
        takeMret  = 1'b0;
        if (state_q == ST_IDLE && commit_valid) begin
            takeIrq   = timer_interrupt & csr_rdata[MSTATUS_MIE];
            takeEcall = ~takeIrq & commit_ecall;
            takeMret  = ~takeIrq & ~commit_ecall & commit_mret;
        end
    end

    // The read port address follows the state so the value needed in each
    // step is already on csr_rdata in that same cycle.
    always_comb begin
        csr_ren   = 1'b0;
        csr_raddr = 12'h000;
        case (state_q)
            ST_IDLE: begin
                csr_ren   = 1'b1;
                csr_raddr = CSR_MSTATUS;
            end
            ST_T_STATUS: begin
                csr_ren   = 1'b1;
                csr_raddr = CSR_MTVEC;
            end
            ST_M_RESTORE: begin
                csr_ren   = 1'b1;
                csr_raddr = CSR_MEPC;
            end
            default: begin
                csr_ren   = 1'b0;
                csr_raddr = 12'h000;
            end
        endcase
    end

    // Sequencer. Write-port and redirect outputs are registered: each
    // transition loads the outputs that belong to the state being entered,
    // so an async reset clears them immediately and nothing else is issued.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            cause_q          <= '0;
            status_q         <= '0;
            wen1_q           <= 1'b0;
            waddr1_q         <= '0;
            wdata1_q         <= '0;
            wen2_q           <= 1'b0;
            waddr2_q         <= '0;
            wdata2_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            wen1_q           <= 1'b0;
            waddr1_q         <= '0;
            wdata1_q         <= '0;
            wen2_q           <= 1'b0;
            waddr2_q         <= '0;
            wdata2_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (takeIrq || takeEcall) begin
                        state_q  <= ST_T_SAVE;
                        cause_q  <= takeIrq ? IRQ_CAUSE : ECALL_CAUSE;
                        status_q <= csr_rdata;
                        wen1_q   <= 1'b1;
                        waddr1_q <= CSR_MEPC;
                        wdata1_q <= commit_pc;
                        wen2_q   <= 1'b1;
                        waddr2_q <= CSR_MCAUSE;
                        wdata2_q <= takeIrq ? IRQ_CAUSE : ECALL_CAUSE;
                    end else if (takeMret) begin
                        state_q  <= ST_M_RESTORE;
                        status_q <= csr_rdata;
                        wen1_q   <= 1'b1;
                        waddr1_q <= CSR_MSTATUS;
                        wdata1_q <= mretStatus(csr_rdata);
                    end
                end
                ST_T_SAVE: begin
                    state_q  <= ST_T_STATUS;
                    wen1_q   <= 1'b1;
                    waddr1_q <= CSR_MSTATUS;
                    wdata1_q <= trapStatus(status_q);
                end
                ST_T_STATUS: begin
                    state_q          <= ST_REDIR;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= trapTarget(csr_rdata, cause_q);
                end
                ST_M_RESTORE: begin
                    state_q          <= ST_REDIR;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= csr_rdata;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign csr_wen1       = wen1_q;
    assign csr_waddr1     = waddr1_q;
    assign csr_wdata1     = wdata1_q;
    assign csr_wen2       = wen2_q;
    assign csr_waddr2     = waddr2_q;
    assign csr_wdata2     = wdata2_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall          = (state_q != ST_IDLE);
    assign commit_kill    = takeIrq | takeEcall | takeMret;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Scoreboard bench for trap_ctrl. A small CSR file model answers the read
// port and absorbs the write ports. Stimulus pushes the CSR-write / redirect
// activity it expects into a queue; a monitor on the falling edge pops one
// entry for every cycle the DUT shows write or redirect activity.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    typedef struct {
        logic        w1;
        logic [11:0] a1;
        logic [63:0] d1;
        logic        w2;
        logic [11:0] a2;
        logic [63:0] d2;
        logic        rv;
        logic [63:0] rpc;
    } expEvent_t;

    logic        clock;
    logic        reset;
    logic        commitValid;
    logic [63:0] commitPc;
    logic        commitEcall;
    logic        commitMret;
    logic        timerInterrupt;
    logic [63:0] csrRdata;
    logic        csrRen;
    logic [11:0] csrRaddr;
    logic        csrWen1;
    logic [11:0] csrWaddr1;
    logic [63:0] csrWdata1;
    logic        csrWen2;
    logic [11:0] csrWaddr2;
    logic [63:0] csrWdata2;
    logic        commitKill;
    logic        stall;
    logic        redirectValid;
    logic [63:0] redirectPc;

    logic [63:0] csrMem [5];
    logic        preEn;
    logic [11:0] preAddr;
    logic [63:0] preData;

    expEvent_t   expQ[$];
    expEvent_t   expHead;
    int          checkCount;
    int          failCount;

    trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
        .clock           (clock),
        .reset           (reset),
        .commit_valid    (commitValid),
        .commit_pc       (commitPc),
        .commit_ecall    (commitEcall),
        .commit_mret     (commitMret),
        .timer_interrupt (timerInterrupt),
        .csr_rdata       (csrRdata),
        .csr_ren         (csrRen),
        .csr_raddr       (csrRaddr),
        .csr_wen1        (csrWen1),
        .csr_waddr1      (csrWaddr1),
        .csr_wdata1      (csrWdata1),
        .csr_wen2        (csrWen2),
        .csr_waddr2      (csrWaddr2),
        .csr_wdata2      (csrWdata2),
        .commit_kill     (commitKill),
        .stall           (stall),
        .redirect_valid  (redirectValid),
        .redirect_pc     (redirectPc)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int csrIdx(input logic [11:0] addr);
        case (addr)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return 4;
        endcase
    endfunction

    // CSR file model: combinational read, writes land on the rising edge.
    always_comb begin
        csrRdata = 64'h0;
        if (csrRen) csrRdata = csrMem[csrIdx(csrRaddr)];
    end

    always @(posedge clock) begin
        if (preEn)   csrMem[csrIdx(preAddr)]   <= preData;
        if (csrWen1) csrMem[csrIdx(csrWaddr1)] <= csrWdata1;
        if (csrWen2) csrMem[csrIdx(csrWaddr2)] <= csrWdata2;
    end

    function automatic expEvent_t mkEvent(input logic w1, input logic [11:0] a1,
                                          input logic [63:0] d1, input logic w2,
                                          input logic [11:0] a2, input logic [63:0] d2,
                                          input logic rv, input logic [63:0] rpc);
        expEvent_t e;
        e.w1 = w1; e.a1 = a1; e.d1 = d1;
        e.w2 = w2; e.a2 = a2; e.d2 = d2;
        e.rv = rv; e.rpc = rpc;
        return e;
    endfunction

    // Monitor: every cycle with write or redirect activity consumes one
    // expected entry; activity with nothing expected is itself a failure.
    always @(negedge clock) begin
        if (reset && (csrWen1 || csrWen2 || redirectValid)) begin
            checkCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpectedEvent got w1=%0b a1=%h d1=%h w2=%0b a2=%h d2=%h rv=%0b pc=%h required no activity",
                         csrWen1, csrWaddr1, csrWdata1, csrWen2, csrWaddr2, csrWdata2, redirectValid, redirectPc);
            end else begin
                expHead = expQ.pop_front();
                if (csrWen1 !== expHead.w1 || csrWen2 !== expHead.w2 || redirectValid !== expHead.rv ||
                    (expHead.w1 && (csrWaddr1 !== expHead.a1 || csrWdata1 !== expHead.d1)) ||
                    (expHead.w2 && (csrWaddr2 !== expHead.a2 || csrWdata2 !== expHead.d2)) ||
                    (expHead.rv && redirectPc !== expHead.rpc)) begin
                    failCount++;
                    $display("[TB] FAIL csrEvent got w1=%0b a1=%h d1=%h w2=%0b a2=%h d2=%h rv=%0b pc=%h required w1=%0b a1=%h d1=%h w2=%0b a2=%h d2=%h rv=%0b pc=%h",
                             csrWen1, csrWaddr1, csrWdata1, csrWen2, csrWaddr2, csrWdata2, redirectValid, redirectPc,
                             expHead.w1, expHead.a1, expHead.d1, expHead.w2, expHead.a2, expHead.d2, expHead.rv, expHead.rpc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s got %h required %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of commit-stage inputs just after the rising edge.
    task automatic applyStimulus(input logic valid, input logic [63:0] pc,
                                 input logic ecall, input logic mret);
        @(posedge clock);
        #1;
        commitValid = valid;
        commitPc    = pc;
        commitEcall = ecall;
        commitMret  = mret;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic preloadCsr(input logic [11:0] addr, input logic [63:0] data);
        @(posedge clock);
        #1;
        preEn   = 1'b1;
        preAddr = addr;
        preData = data;
        @(posedge clock);
        #1;
        preEn   = 1'b0;
    endtask

    // Push the three events of a full trap entry.
    task automatic expectTrap(input logic [63:0] pc, input logic [63:0] cause,
                              input logic [63:0] newStatus, input logic [63:0] target);
        expQ.push_back(mkEvent(1'b1, 12'h341, pc, 1'b1, 12'h342, cause, 1'b0, 64'h0));
        expQ.push_back(mkEvent(1'b1, 12'h300, newStatus, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0));
        expQ.push_back(mkEvent(1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0, 1'b1, target));
    endtask

    initial begin
        checkCount     = 0;
        failCount      = 0;
        reset          = 1'b0;
        commitValid    = 1'b0;
        commitPc       = 64'h0;
        commitEcall    = 1'b0;
        commitMret     = 1'b0;
        timerInterrupt = 1'b0;
        preEn          = 1'b0;
        preAddr        = 12'h0;
        preData        = 64'h0;
        for (int i = 0; i < 5; i++) csrMem[i] = 64'h0;

        // Reset state
        @(negedge clock);
        checkOutput("resetStall", {63'h0, stall}, 64'h0);
        checkOutput("resetWen1", {63'h0, csrWen1}, 64'h0);
        checkOutput("resetWen2", {63'h0, csrWen2}, 64'h0);
        checkOutput("resetRedirect", {63'h0, redirectValid}, 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("idleRen", {63'h0, csrRen}, 64'h1);
        checkOutput("idleRaddr", {52'h0, csrRaddr}, 64'h300);

        // ecall, direct mtvec, MIE=1
        preloadCsr(12'h300, 64'h8);
        preloadCsr(12'h305, 64'h8000_1000);
        expectTrap(64'h8000_0010, 64'd11, 64'h1880, 64'h8000_1000);
        applyStimulus(1'b1, 64'h8000_0010, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("ecallKill", {63'h0, commitKill}, 64'h1);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("ecallStallT1", {63'h0, stall}, 64'h1);
        idleCycles(4);

        // mret with MPIE=1, MIE=0
        preloadCsr(12'h341, 64'h8000_0014);
        expQ.push_back(mkEvent(1'b1, 12'h300, 64'h1888, 1'b0, 12'h0, 64'h0, 1'b0, 64'h0));
        expQ.push_back(mkEvent(1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0, 1'b1, 64'h8000_0014));
        applyStimulus(1'b1, 64'h8000_0018, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("mretKill", {63'h0, commitKill}, 64'h1);
        idleCycles(4);

        // Timer interrupt together with ecall, vectored mtvec
        preloadCsr(12'h305, 64'h8000_1001);
        expectTrap(64'h8000_0020, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_101C);
        timerInterrupt = 1'b1;
        applyStimulus(1'b1, 64'h8000_0020, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("irqKill", {63'h0, commitKill}, 64'h1);
        idleCycles(5);

        // Timer still high, MIE=0: a plain instruction is not interrupted
        applyStimulus(1'b1, 64'h8000_0024, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("maskedIrqKill", {63'h0, commitKill}, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("maskedIrqStall", {63'h0, stall}, 64'h0);

        // ecall inside the handler with MIE=0 is still taken, direct target
        expectTrap(64'h8000_0030, 64'd11, 64'h1800, 64'h8000_1000);
        applyStimulus(1'b1, 64'h8000_0030, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("handlerEcallKill", {63'h0, commitKill}, 64'h1);
        idleCycles(5);
        timerInterrupt = 1'b0;

        // ecall with commit_valid=0 is ignored
        applyStimulus(1'b0, 64'h8000_0038, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("invalidEcallKill", {63'h0, commitKill}, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("invalidEcallStall", {63'h0, stall}, 64'h0);

        // ecall presented again while stalled is ignored
        expectTrap(64'h8000_0040, 64'd11, 64'h1800, 64'h8000_1000);
        applyStimulus(1'b1, 64'h8000_0040, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("stallSeqKill", {63'h0, commitKill}, 64'h1);
        applyStimulus(1'b1, 64'h8000_0044, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("stalledEcallKill", {63'h0, commitKill}, 64'h0);
        applyStimulus(1'b1, 64'h8000_0044, 1'b1, 1'b0);
        @(negedge clock);
        checkOutput("stalledEcallKill2", {63'h0, commitKill}, 64'h0);
        idleCycles(5);

        // Reset asserted during T_STATUS aborts the sequence
        preloadCsr(12'h300, 64'h8);
        preloadCsr(12'h305, 64'h8000_1000);
        expQ.push_back(mkEvent(1'b1, 12'h341, 64'h8000_0050, 1'b1, 12'h342, 64'd11, 1'b0, 64'h0));
        applyStimulus(1'b1, 64'h8000_0050, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abortWen1", {63'h0, csrWen1}, 64'h0);
        checkOutput("abortStall", {63'h0, stall}, 64'h0);
        checkOutput("abortRedirect", {63'h0, redirectValid}, 64'h0);
        idleCycles(2);
        reset = 1'b1;
        idleCycles(5);
        @(negedge clock);
        checkOutput("abortStallAfter", {63'h0, stall}, 64'h0);
        checkOutput("abortMepcKept", csrMem[2], 64'h8000_0050);
        checkOutput("abortMcauseKept", csrMem[3], 64'd11);
        checkOutput("abortMstatusUntouched", csrMem[0], 64'h8);

        // Every expected event must have been observed
        checkOutput("pendingEvents", 64'(expQ.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the commit stage and the CSR register file.
- Detects timer interrupt, ecall and mret at an instruction boundary.
- Drives the CSR file's two write ports and its read port over a fixed multi-cycle sequence.
- Stalls the pipeline during the sequence, then issues a one-cycle PC redirect.

Parameters:
- XLEN, 64, data/PC width.
- VECTORED_EN, 1, honour mtvec.MODE=1 for interrupts (0: always direct).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- commit_valid  in  1  instruction at commit boundary this cycle
- commit_pc  in  XLEN  PC of that instruction
- commit_ecall  in  1  instruction is ecall
- commit_mret  in  1  instruction is mret
- timer_interrupt  in  1  pending timer interrupt from CSR file
- csr_rdata  in  XLEN  CSR file read data (combinational w.r.t. csr_raddr)
- csr_ren  out  1  CSR read enable
- csr_raddr  out  12  CSR read address
- csr_wen1  out  1  CSR write port 1 enable
- csr_waddr1  out  12  port 1 address
- csr_wdata1  out  XLEN  port 1 data
- csr_wen2  out  1  CSR write port 2 enable
- csr_waddr2  out  12  port 2 address
- csr_wdata2  out  XLEN  port 2 data
- commit_kill  out  1  squash the committing instruction (combinational, IDLE only)
- stall  out  1  hold pipeline; high whenever state != IDLE
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (reset=0, async): state=IDLE; all registered outputs 0.
  - Mid-sequence reset aborts with no redirect.
  - CSR writes already committed remain.
- IDLE: csr_ren=1, csr_raddr=0x300; status = csr_rdata.
  - Accept only when commit_valid=1.
  - Priority: interrupt (timer_interrupt & status[3]) > ecall > mret.
  - On accept: latch epc=commit_pc.
  - Latch cause: 0x8000_0000_0000_0007 for interrupt, 11 for ecall.
  - Latch status.
  - commit_kill=1 the same cycle for any accepted event.
- Trap path: IDLE -> T_SAVE -> T_STATUS -> REDIR -> IDLE.
  - T_SAVE: wen1 mepc(0x341)=epc; wen2 mcause(0x342)=cause.
  - T_STATUS: wen1 mstatus(0x300)=status with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - T_STATUS: read mtvec(0x305), latch tvec.
  - REDIR: redirect_valid=1.
  - Target, direct: redirect_pc = {tvec[XLEN-1:2],2'b00}.
  - Target, vectored (VECTORED_EN=1, tvec[1:0]=01, interrupt): base + 4*cause[5:0] (= base+0x1C for the timer).
  - Target, any other tvec[1:0]: treated as direct.
- Mret path: IDLE -> M_RESTORE -> REDIR -> IDLE.
  - M_RESTORE: wen1 mstatus = status with MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - M_RESTORE: read mepc(0x341), latch target.
  - REDIR: redirect_pc = target.
- Latency from accept cycle T0 to redirect strobe: trap T3, mret T2.
- wen2 is used only in T_SAVE; writes in all other states are 0.
- Port-1 and port-2 addresses never collide.
- Requests are ignored while stall=1; the pipeline holds commit_valid=0 until redirect.
- timer_interrupt held high after trap entry is not re-taken: status[3]=0 after T_STATUS.
- An ecall in a handler with MIE=0 is still taken.
- Simultaneous interrupt+ecall: interrupt taken and ecall killed.
- The ecall re-executes after mret (mepc=its PC).
- Arithmetic is XLEN-wide; vector offset wraps modulo 2^XLEN.

Decomposition:
- Shared package holds:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342).
  - mstatus bit indices (MIE 3, MPIE 7, MPP 12:11).
  - Cause codes (ECALL_M 11, MTI interrupt 7).
  - State enum.
- No sub-module needed; the target-PC computation may be split out as trap_vec_calc if reused.

Test Plan:
- ecall at commit_pc=0x8000_0010, mtvec=0x8000_1000, MIE=1:
  - kill at T0.
  - T1 mepc=0x8000_0010, mcause=11.
  - T2 mstatus MIE=0, MPIE=1, MPP=3.
  - T3 redirect_pc=0x8000_1000.
- Timer interrupt with MIE=1, mtvec=0x8000_1001 (vectored) -> mcause=0x8000_0000_0000_0007, redirect_pc=0x8000_101C.
- mret with mstatus MPIE=1, MIE=0, mepc=0x8000_0014 -> T1 mstatus MIE=1, MPIE=1; T2 redirect_pc=0x8000_0014; no wen2.
- timer_interrupt and ecall in the same cycle -> interrupt cause written, ecall killed; timer_interrupt held high through handler with MIE=0 -> no second trap.
- commit_ecall asserted while stall=1, or with commit_valid=0 -> ignored, no CSR writes.
- reset driven low during T_STATUS -> outputs 0 immediately, no redirect, state IDLE after release; mepc/mcause retain T1 values.
